bk_sector_seq: RTL and testbench
================================

# bk_sector_seq

Backup-RAM save/load sequencer between the HPS SD sector interface and the cartridge backup RAM in `system`. It detects manual load/save commands, OSD-close autosave, and post-download auto-load. Each operation steps `sd_lba` through a fixed sector range using the `sd_rd`/`sd_wr`/`sd_ack` handshake. It also holds the core in reset while a load is in progress.

## Interface
Parameters:
- `SECTORS`, 128: sectors per operation; must be a power of two.
- `LBA_W`, 32: width of `sd_lba`.

Ports:
- `clk_sys` in 1: system clock.
- `reset` in 1: asynchronous, active-high.
- `downloading` in 1: ROM download in progress.
- `img_mounted` in 1: save image mount pulse.
- `img_readonly` in 1: mounted image is read-only.
- `img_size_nz` in 1: mounted image size is non-zero.
- `load_req` in 1: manual load, level; acts on rising edge.
- `save_req` in 1: manual save, level; acts on rising edge.
- `autosave_en` in 1: autosave option.
- `osd_status` in 1: OSD open.
- `bram_change` in 1: backup RAM written by the core.
- `sd_ack` in 1: HPS sector acknowledge.
- `sd_lba` out LBA_W: current sector.
- `sd_rd` out 1: sector read request.
- `sd_wr` out 1: sector write request.
- `bk_ena` out 1: writable save image present.
- `bk_loading` out 1: load in progress; ORed into the core reset.
- `busy` out 1: operation in progress.
- `sav_pending` out 1: unsaved changes; drives the LED.

## Operation
- `bk_ena`:
  - Cleared on the rising edge of `downloading`.
  - Set when `downloading & img_mounted & ~img_readonly`.
  - If both occur in the same cycle, set wins.
- `sav_pending`:
  - Set when `bram_change & ~osd_status`.
  - Otherwise cleared while `busy`.
  - Set has priority over clear.
- Save trigger is `save_req | (sav_pending & osd_status & autosave_en)`. It is edge-detected against a registered copy of itself.
- Load trigger is the rising edge of `load_req`.
- Auto-load trigger is the falling edge of `downloading` while `img_size_nz & bk_ena`.
- State machine, with states IDLE, REQ and XFER:
  - IDLE, `bk_ena` and trigger present: `sd_lba`←0, `bk_loading`←load, `sd_rd`←load, `sd_wr`←~load, go to REQ.
  - IDLE, trigger present but `bk_ena`=0: trigger is ignored and not queued.
  - IDLE, auto-load trigger: it needs no manual edge and is evaluated after the manual triggers.
  - REQ, rising edge of `sd_ack`: `sd_rd`←0, `sd_wr`←0, go to XFER.
  - XFER, falling edge of `sd_ack`, `sd_lba[log2 SECTORS-1:0]` all ones: `bk_loading`←0, go to IDLE.
  - XFER, falling edge of `sd_ack`, otherwise: `sd_lba`←`sd_lba`+1, reassert `sd_rd`=`bk_loading`, `sd_wr`=~`bk_loading`, go to REQ.
- Trigger priority in IDLE: load > save > auto-load. Triggers arriving during REQ/XFER are dropped, except that autosave re-fires on the next qualifying edge.
- `busy` = (state != IDLE).
- `sd_ack` edges seen outside the expected state are ignored.

## Timing
- Reset values: `sd_lba`=0, `sd_rd`=0, `sd_wr`=0, `bk_ena`=0, `bk_loading`=0, `busy`=0, `sav_pending`=0, state IDLE, all edge registers 0.
- Trigger high at cycle N with its registered copy low → request asserted and `busy`=1 at N+1.
- `sd_ack` rises at cycle M → request low at M+1.
- `sd_ack` falls at cycle F → next request at F+1 with incremented `sd_lba`. On the last sector, `busy`=0 and `bk_loading`=0 at F+1.
- Minimum of 3 cycles per sector beyond HPS latency. No timeout: the sequencer waits indefinitely on `sd_ack`.
- Reset mid-operation: immediate return to reset values, no partial-sector cleanup. `bk_loading` drops, releasing the core.
- `sd_lba` upper bits stay 0; the counter wraps only within the low log2(SECTORS) bits.

## Structure
- Package `bk_pkg` holds the state enum (IDLE, REQ, XFER) and the default `SECTORS` constant.
- One sub-module, `edge_det`: registered rising/falling edge detector. It is instanced for `sd_ack`, `downloading`, `load_req` and the save trigger.
- Everything else is a single always_ff process plus an output assign.

## Test plan
- Auto-load: `bk_ena` set via mount, `img_size_nz`=1, `downloading` falls → 128 reads on LBA 0..127, `bk_loading`=1 throughout, 0 one cycle after the 128th `sd_ack` fall.
- Manual save: `save_req` pulse → `sd_wr`=1 at N+1, `sd_rd` never 1. `sav_pending` previously 1 is cleared while busy. Ends at LBA 127.
- Autosave: `bram_change` with OSD closed → `sav_pending`=1. OSD opens with `autosave_en`=1 → write sequence starts. Same with `autosave_en`=0 → no activity.
- Gating: read-only image mounted, then `load_req` → no request, `busy` stays 0. Simultaneous `load_req` and `save_req` edges with `bk_ena`=1 → read sequence only.
- Reset mid-load: assert `reset` at LBA 37 in XFER → next cycle all outputs 0. After release, a new load starts at LBA 0.
- Ignored edges: `sd_ack` toggles while IDLE → no output change. `load_req` edge during a save → save completes and no load follows.

Source files
------------

// File: rtl/bk_pkg.sv
// Shared definitions for the backup-RAM sector sequencer.
package bk_pkg;

  localparam int SECTORS_DEF = 128;

  typedef logic [1:0] bk_state_t;

  localparam bk_state_t ST_IDLE = 2'd0;
  localparam bk_state_t ST_REQ  = 2'd1;
  localparam bk_state_t ST_XFER = 2'd2;

endpackage

// File: rtl/bk_sector_seq_edge_det.sv
// Registered edge detector: compares a level against its copy from the previous cycle.
module edge_det (
  input  logic clk_sys,
  input  logic reset,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic d_reg;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      d_reg <= 1'b0;
    end else begin
      d_reg <= d;
    end
  end

  assign rise = d & ~d_reg;
  assign fall = ~d & d_reg;

endmodule

// File: rtl/bk_sector_seq.sv
// Backup-RAM save/load sequencer: walks a fixed sector range over the HPS
// sd_rd/sd_wr/sd_ack handshake and holds the core in reset during loads.
module bk_sector_seq
  import bk_pkg::*;
#(
  parameter int SECTORS = SECTORS_DEF,
  parameter int LBA_W   = 32
) (
  input  logic             clk_sys,
  input  logic             reset,
  input  logic             downloading,
  input  logic             img_mounted,
  input  logic             img_readonly,
  input  logic             img_size_nz,
  input  logic             load_req,
  input  logic             save_req,
  input  logic             autosave_en,
  input  logic             osd_status,
  input  logic             bram_change,
  input  logic             sd_ack,
  output logic [LBA_W-1:0] sd_lba,
  output logic             sd_rd,
  output logic             sd_wr,
  output logic             bk_ena,
  output logic             bk_loading,
  output logic             busy,
  output logic             sav_pending
);

  localparam int CNT_W = (SECTORS > 1) ? $clog2(SECTORS) : 1;

  bk_state_t        state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             sd_rd_reg;
  logic             sd_wr_reg;
  logic             bk_ena_reg;
  logic             bk_loading_reg;
  logic             sav_pending_reg;

  logic save_trig;
  logic ack_rise, ack_fall;
  logic dl_rise, dl_fall;
  logic load_rise, load_fall_unused;
  logic save_rise, save_fall_unused;

  assign save_trig = save_req | (sav_pending_reg & osd_status & autosave_en);

  edge_det u_ack_edge (
    .clk_sys (clk_sys), .reset (reset), .d (sd_ack),
    .rise (ack_rise), .fall (ack_fall)
  );
  edge_det u_dl_edge (
    .clk_sys (clk_sys), .reset (reset), .d (downloading),
    .rise (dl_rise), .fall (dl_fall)
  );
  edge_det u_load_edge (
    .clk_sys (clk_sys), .reset (reset), .d (load_req),
    .rise (load_rise), .fall (load_fall_unused)
  );
  edge_det u_save_edge (
    .clk_sys (clk_sys), .reset (reset), .d (save_trig),
    .rise (save_rise), .fall (save_fall_unused)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      sd_rd_reg       <= 1'b0;
      sd_wr_reg       <= 1'b0;
      bk_ena_reg      <= 1'b0;
      bk_loading_reg  <= 1'b0;
      sav_pending_reg <= 1'b0;
    end else begin
      // A mount during the download must survive the download's own rising edge.
      if (downloading & img_mounted & ~img_readonly) begin
        bk_ena_reg <= 1'b1;
      end else if (dl_rise) begin
        bk_ena_reg <= 1'b0;
      end

      if (bram_change & ~osd_status) begin
        sav_pending_reg <= 1'b1;
      end else if (state_reg != ST_IDLE) begin
        sav_pending_reg <= 1'b0;
      end

      case (state_reg)
        ST_IDLE: begin
          if (bk_ena_reg) begin
            if (load_rise || (!save_rise && dl_fall && img_size_nz)) begin
              cnt_reg        <= '0;
              bk_loading_reg <= 1'b1;
              sd_rd_reg      <= 1'b1;
              sd_wr_reg      <= 1'b0;
              state_reg      <= ST_REQ;
            end else if (save_rise) begin
              cnt_reg        <= '0;
              bk_loading_reg <= 1'b0;
              sd_rd_reg      <= 1'b0;
              sd_wr_reg      <= 1'b1;
              state_reg      <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          if (ack_rise) begin
            sd_rd_reg <= 1'b0;
            sd_wr_reg <= 1'b0;
            state_reg <= ST_XFER;
          end
        end
        ST_XFER: begin
          if (ack_fall) begin
            if (&cnt_reg) begin
              bk_loading_reg <= 1'b0;
              state_reg      <= ST_IDLE;
            end else begin
              cnt_reg   <= cnt_reg + CNT_W'(1);
              sd_rd_reg <= bk_loading_reg;
              sd_wr_reg <= ~bk_loading_reg;
              state_reg <= ST_REQ;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign sd_lba      = {{(LBA_W-CNT_W){1'b0}}, cnt_reg};
  assign sd_rd       = sd_rd_reg;
  assign sd_wr       = sd_wr_reg;
  assign bk_ena      = bk_ena_reg;
  assign bk_loading  = bk_loading_reg;
  assign busy        = (state_reg != ST_IDLE);
  assign sav_pending = sav_pending_reg;

endmodule

// File: tb/tb_bk_sector_seq.sv
// Self-checking bench for bk_sector_seq: HPS responder, request scoreboard,
// trigger-priority vector table and hand-written multi-cycle sequences.
module tb_bk_sector_seq;

  localparam int SECT = 128;

  logic        clk_sys;
  logic        reset;
  logic        downloading, img_mounted, img_readonly, img_size_nz;
  logic        load_req, save_req, autosave_en, osd_status, bram_change;
  logic        sd_ack;
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr, bk_ena, bk_loading, busy, sav_pending;

  int checks = 0;
  int errors = 0;
  int hps_mode = 0;  // 0 = idle low, 1 = answer requests, 2 = free toggle

  typedef struct packed {
    logic [31:0] lba;
    logic        rd;
    logic        wr;
    logic        load;
  } req_t;
  req_t exp_q[$];

  typedef struct {
    logic ld;
    logic sv;
    logic erd;
    logic ewr;
    logic ebusy;
  } vec_t;
  vec_t vecs[4];

  bk_sector_seq dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .downloading  (downloading),
    .img_mounted  (img_mounted),
    .img_readonly (img_readonly),
    .img_size_nz  (img_size_nz),
    .load_req     (load_req),
    .save_req     (save_req),
    .autosave_en  (autosave_en),
    .osd_status   (osd_status),
    .bram_change  (bram_change),
    .sd_ack       (sd_ack),
    .sd_lba       (sd_lba),
    .sd_rd        (sd_rd),
    .sd_wr        (sd_wr),
    .bk_ena       (bk_ena),
    .bk_loading   (bk_loading),
    .busy         (busy),
    .sav_pending  (sav_pending)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic push_op(input logic load);
    req_t e;
    for (int i = 0; i < SECT; i++) begin
      e.lba  = 32'(i);
      e.rd   = load;
      e.wr   = ~load;
      e.load = load;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk_sys);
      n++;
    end while (busy && n < 3000);
    chk("idle_timeout", busy, 1'b0);
  endtask

  // Follows the operation to its last sector and checks the release timing.
  task automatic end_check(input logic load);
    logic pa;
    int   n;
    pa = 1'b0;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk_sys);
      if (pa && !sd_ack && sd_lba == 32'(SECT-1)) break;
      pa = sd_ack;
    end
    if (n == 3000) begin
      checks++;
      errors++;
      $display("FAIL end_timeout: last sd_ack fall not seen, required within 3000 cycles");
    end else begin
      chk("last_busy_held", busy, 1'b1);
      chk("last_loading_held", bk_loading, load);
      @(negedge clk_sys);
      chk("end_busy", busy, 1'b0);
      chk("end_loading", bk_loading, 1'b0);
      chk("end_lba", sd_lba, 32'(SECT-1));
    end
  endtask

  task automatic enable(input logic ro, input logic sz);
    tick();
    downloading = 1'b1;
    img_readonly = ro;
    img_size_nz = sz;
    tick();
    img_mounted = 1'b1;
    tick();
    img_mounted = 1'b0;
    tick();
    if (sz && !ro) push_op(1'b1);
    downloading = 1'b0;
  endtask

  // HPS model
  initial begin
    sd_ack = 1'b0;
    forever begin
      @(posedge clk_sys);
      #1;
      if (hps_mode == 2) begin
        sd_ack = ~sd_ack;
      end else if (hps_mode == 1 && (sd_rd || sd_wr) && !sd_ack) begin
        @(posedge clk_sys);
        #1;
        if (sd_rd || sd_wr) begin
          sd_ack = 1'b1;
          repeat (2) @(posedge clk_sys);
          #1;
          sd_ack = 1'b0;
        end
      end else if (hps_mode == 0) begin
        sd_ack = 1'b0;
      end
    end
  end

  // Request monitor / scoreboard
  initial begin
    logic prev_req;
    req_t e;
    prev_req = 1'b0;
    forever begin
      @(negedge clk_sys);
      if ((sd_rd || sd_wr) && !prev_req) begin
        $display("REQ lba=%0d rd=%0b wr=%0b loading=%0b", sd_lba, sd_rd, sd_wr, bk_loading);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: lba %0d rd %0b wr %0b, required no request", sd_lba, sd_rd, sd_wr);
        end else begin
          e = exp_q.pop_front();
          chk("req_lba", sd_lba, e.lba);
          chk("req_rd", sd_rd, e.rd);
          chk("req_wr", sd_wr, e.wr);
          chk("req_loading", bk_loading, e.load);
        end
      end
      prev_req = sd_rd | sd_wr;
    end
  end

  initial begin
    #400us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0] = '{ld: 1'b0, sv: 1'b0, erd: 1'b0, ewr: 1'b0, ebusy: 1'b0};
    vecs[1] = '{ld: 1'b1, sv: 1'b0, erd: 1'b1, ewr: 1'b0, ebusy: 1'b1};
    vecs[2] = '{ld: 1'b0, sv: 1'b1, erd: 1'b0, ewr: 1'b1, ebusy: 1'b1};
    vecs[3] = '{ld: 1'b1, sv: 1'b1, erd: 1'b1, ewr: 1'b0, ebusy: 1'b1};

    reset = 1'b1;
    downloading = 0; img_mounted = 0; img_readonly = 0; img_size_nz = 0;
    load_req = 0; save_req = 0; autosave_en = 0; osd_status = 0; bram_change = 0;
    repeat (3) tick();
    reset = 1'b0;
    @(negedge clk_sys);
    chk("rst_lba", sd_lba, 0);
    chk("rst_rd", sd_rd, 0);
    chk("rst_wr", sd_wr, 0);
    chk("rst_bk_ena", bk_ena, 0);
    chk("rst_loading", bk_loading, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pending", sav_pending, 0);

    // sd_ack activity while idle changes nothing
    hps_mode = 2;
    repeat (8) begin
      @(negedge clk_sys);
      chk("idle_ack_busy", busy, 0);
      chk("idle_ack_req", {sd_rd, sd_wr}, 2'b00);
    end
    hps_mode = 0;
    tick();
    tick();
    hps_mode = 1;

    // read-only image gates everything
    enable(1'b1, 1'b1);
    repeat (4) @(negedge clk_sys);
    chk("ro_bk_ena", bk_ena, 0);
    tick();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    repeat (6) @(negedge clk_sys);
    chk("ro_busy", busy, 0);
    chk("ro_rd", sd_rd, 0);

    // writable mount then auto-load on download end
    enable(1'b0, 1'b1);
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk("auto_bk_ena", bk_ena, 1);
    chk("auto_rd", sd_rd, 1);
    chk("auto_loading", bk_loading, 1);
    end_check(1'b1);
    img_size_nz = 1'b0;

    // trigger priority table
    for (int i = 0; i < 4; i++) begin
      tick();
      if (vecs[i].ebusy) push_op(vecs[i].erd);
      load_req = vecs[i].ld;
      save_req = vecs[i].sv;
      @(posedge clk_sys);
      @(negedge clk_sys);
      chk("vec_rd", sd_rd, vecs[i].erd);
      chk("vec_wr", sd_wr, vecs[i].ewr);
      chk("vec_busy", busy, vecs[i].ebusy);
      load_req = 1'b0;
      save_req = 1'b0;
      wait_idle();
    end

    // manual save clears pending changes
    tick();
    bram_change = 1'b1;
    tick();
    bram_change = 1'b0;
    @(negedge clk_sys);
    chk("pend_set", sav_pending, 1);
    tick();
    push_op(1'b0);
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    repeat (4) @(negedge clk_sys);
    chk("save_busy", busy, 1);
    chk("save_pend_clr", sav_pending, 0);
    end_check(1'b0);

    // load edge during a save is dropped
    tick();
    push_op(1'b0);
    save_req = 1'b1;
    tick();
    save_req = 1'b0;
    repeat (40) tick();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    end_check(1'b0);
    repeat (10) @(negedge clk_sys);
    chk("no_late_load", busy, 0);

    // autosave on OSD open
    tick();
    bram_change = 1'b1;
    tick();
    bram_change = 1'b0;
    push_op(1'b0);
    autosave_en = 1'b1;
    osd_status = 1'b1;
    @(posedge clk_sys);
    @(negedge clk_sys);
    chk("autosave_wr", sd_wr, 1);
    end_check(1'b0);
    chk("autosave_pend", sav_pending, 0);
    tick();
    osd_status = 1'b0;
    autosave_en = 1'b0;

    // autosave disabled: no activity
    tick();
    bram_change = 1'b1;
    tick();
    bram_change = 1'b0;
    osd_status = 1'b1;
    n = 0;
    repeat (20) begin
      @(negedge clk_sys);
      if (busy) n++;
    end
    chk("noauto_busy_cycles", n, 0);
    chk("noauto_pend", sav_pending, 1);
    tick();
    osd_status = 1'b0;

    // reset in the middle of a load
    tick();
    push_op(1'b1);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    for (n = 0; n < 3000; n++) begin
      @(negedge clk_sys);
      if (sd_lba == 32'd37 && busy && !sd_rd && sd_ack) break;
    end
    chk("mid_reach_37", sd_lba, 37);
    reset = 1'b1;
    exp_q.delete();
    tick();
    chk("mid_rst_lba", sd_lba, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_loading", bk_loading, 0);
    chk("mid_rst_req", {sd_rd, sd_wr}, 2'b00);
    chk("mid_rst_bk_ena", bk_ena, 0);
    tick();
    reset = 1'b0;
    repeat (4) tick();
    enable(1'b0, 1'b0);
    tick();
    push_op(1'b1);
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    @(negedge clk_sys);
    chk("reload_lba0", sd_lba, 0);
    chk("reload_rd", sd_rd, 1);
    end_check(1'b1);

    repeat (5) @(negedge clk_sys);
    chk("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
